// File: rtl/lib_pkg.sv
// rtl/lib_pkg.sv - shared types, funct3 codes and helpers for the data-memory unit
// Purpose: access-size and FSM-state enums, RISC-V load/store funct3 codes,
//          and small decode/extend helpers used by dmem_unit.
// Ports:   none (package).
package lib_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPLIT = 2'd1,
    RESP  = 2'd2
  } dmem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic mem_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return MEM_B;
      2'd1:    return MEM_H;
      default: return MEM_W;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input mem_size_t s);
    case (s)
      MEM_B:   return 3'd1;
      MEM_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input mem_size_t s);
    case (s)
      MEM_B:   return 4'b0001;
      MEM_H:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // uns=1 selects zero extension (funct3[2]), otherwise sign extension.
  function automatic logic [31:0] load_extend(input logic [31:0] d, input mem_size_t s,
                                              input logic uns);
    case (s)
      MEM_B:   return uns ? {24'b0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      MEM_H:   return uns ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port byte-strobed synchronous word RAM
// Purpose: DEPTH x 32 storage with registered, read-first output.
// Ports:   clk; en (access enable); we (write); be[3:0] byte strobes;
//          addr[AW-1:0] word index; wdata[31:0]; rdata[31:0] (old word at addr).
module dmem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Contents are deliberately not reset; rdata returns the pre-write word.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_unit.sv
// rtl/dmem_unit.sv - load/store responder with misaligned split accesses
// Purpose: accepts one load/store at a time, splits word-crossing accesses into
//          two RAM cycles, merges/extends load data, flags illegal funct3.
// Ports:   clk, rst_n (sync, active-low); req_valid/req_we/req_funct3/req_addr/
//          req_wdata request; req_ready (idle); rsp_valid pulse, rsp_rdata, rsp_err.
module dmem_unit
  import lib_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  dmem_state_t state;

  // Request fields latched at acceptance.
  logic          we_q;
  logic          uns_q;
  logic          cross_q;
  logic          err_q;
  mem_size_t     size_q;
  logic [1:0]    off_q;
  logic [AW-1:0] w1_q;
  logic [3:0]    be_hi_q;
  logic [31:0]   wdata_hi_q;
  logic [31:0]   rd_w0_q;
  logic [31:0]   rdata_hold;

  // Request decode.
  logic [1:0]    req_off;
  logic [AW-1:0] req_w0;
  mem_size_t     req_size;
  logic          req_legal;
  logic          req_cross;
  logic [63:0]   wide_data;
  logic [7:0]    wide_be;
  logic          accept;

  // Address bits above the word index alias; they are intentionally dropped.
  logic          unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  assign req_off   = req_addr[1:0];
  assign req_w0    = req_addr[AW+1:2];
  assign req_size  = f3_size(req_funct3);
  assign req_legal = f3_legal(req_we, req_funct3);
  assign req_cross = ({1'b0, req_off} + size_bytes(req_size)) > 3'd4;
  assign wide_data = {32'b0, req_wdata} << {req_off, 3'b000};
  assign wide_be   = {4'b0, size_mask(req_size)} << req_off;
  assign req_ready = (state == IDLE);
  assign accept    = rst_n && (state == IDLE) && req_valid;

  // RAM port is steered by the request in IDLE and by the latched upper half in SPLIT.
  logic          ram_en;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state == IDLE) begin
      ram_en    = accept && req_legal;
      ram_we    = req_we;
      ram_be    = wide_be[3:0];
      ram_addr  = req_w0;
      ram_wdata = wide_data[31:0];
    end else if (state == SPLIT) begin
      // Gated by rst_n so a reset during SPLIT drops the second half of a store.
      ram_en    = rst_n;
      ram_we    = we_q;
      ram_be    = be_hi_q;
      ram_addr  = w1_q;
      ram_wdata = wdata_hi_q;
    end
  end

  dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Load merge: the RAM output still holds the most recent word read (w0 when
  // not crossing, w1 when crossing) throughout RESP, since the RAM idles then.
  logic [31:0] merge_lo;
  logic [31:0] merge_hi;
  logic [63:0] merged;
  logic [31:0] rsp_now;

  assign merge_lo = cross_q ? rd_w0_q : ram_rdata;
  assign merge_hi = cross_q ? ram_rdata : 32'b0;
  assign merged   = {merge_hi, merge_lo} >> {off_q, 3'b000};
  assign rsp_now  = (err_q || we_q) ? 32'b0 : load_extend(merged[31:0], size_q, uns_q);

  // Live value during the response cycle, held value afterwards.
  assign rsp_rdata = (state == RESP) ? rsp_now : rdata_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      cross_q    <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= MEM_B;
      off_q      <= 2'b0;
      w1_q       <= '0;
      be_hi_q    <= 4'b0;
      wdata_hi_q <= 32'b0;
      rd_w0_q    <= 32'b0;
      rdata_hold <= 32'b0;
    end else begin
      case (state)
        IDLE: begin
          rsp_err <= 1'b0;
          if (req_valid) begin
            we_q       <= req_we;
            uns_q      <= req_funct3[2];
            size_q     <= req_size;
            off_q      <= req_off;
            cross_q    <= req_legal && req_cross;
            err_q      <= !req_legal;
            w1_q       <= req_w0 + AW'(1);
            be_hi_q    <= req_legal ? wide_be[7:4] : 4'b0;
            wdata_hi_q <= wide_data[63:32];
            if (!req_legal) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (req_cross) begin
              state <= SPLIT;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end
          end
        end
        SPLIT: begin
          rd_w0_q   <= ram_rdata;
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          rsp_valid  <= 1'b0;
          rsp_err    <= 1'b0;
          rdata_hold <= rsp_now;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_unit.sv
// tb/tb_dmem_unit.sv - directed self-checking bench for dmem_unit
module tb_dmem_unit;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  dmem_unit #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns data, error flag, latency.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    logic seen;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat  = 0;
    rd   = 32'b0;
    er   = 1'b0;
    seen = 1'b0;
    while (!seen && lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, "_busy"}, 32'(req_ready), 32'd0);
      if (rsp_valid) begin
        seen = 1'b1;
        rd   = rsp_rdata;
        er   = rsp_err;
      end
    end
    @(negedge clk);
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] exp, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(tag, 1'b0, f3, addr, 32'b0, rd, er, lat);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, 32'(er), 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic st(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(tag, 1'b1, f3, addr, wd, rd, er, lat);
    check({tag, "_data"}, rd, 32'd0);
    check({tag, "_err"}, 32'(er), 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic bad(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(tag, we, f3, addr, wd, rd, er, lat);
    check({tag, "_data"}, rd, 32'd0);
    check({tag, "_err"}, 32'(er), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_err_clr"}, 32'(rsp_err), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = 32'b0;
    req_wdata  = 32'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;

    // Aligned word store/load.
    st("sw100", 3'b010, 32'h100, 32'hDEADBEEF, 1);
    ld("lw100", 3'b010, 32'h100, 32'hDEADBEEF, 1);

    // Byte/half extension.
    st("sw200", 3'b010, 32'h200, 32'h80FF7F01, 1);
    ld("lb203", 3'b000, 32'h203, 32'hFFFFFF80, 1);
    ld("lbu203", 3'b100, 32'h203, 32'h00000080, 1);
    ld("lh202", 3'b001, 32'h202, 32'hFFFF80FF, 1);
    ld("lhu202", 3'b101, 32'h202, 32'h000080FF, 1);
    ld("lb201", 3'b000, 32'h201, 32'h0000007F, 1);
    check("hold_rdata", rsp_rdata, 32'h0000007F);

    // Crossing word store and misaligned loads.
    st("z300", 3'b010, 32'h300, 32'h0, 1);
    st("z304", 3'b010, 32'h304, 32'h0, 1);
    st("sw301", 3'b010, 32'h301, 32'h11223344, 2);
    ld("lw300", 3'b010, 32'h300, 32'h22334400, 1);
    ld("lw304", 3'b010, 32'h304, 32'h00000011, 1);
    ld("lw301", 3'b010, 32'h301, 32'h11223344, 2);
    ld("lh303", 3'b001, 32'h303, 32'h00001122, 2);

    // Crossing halfword store, including wrap from the last word to word 0.
    st("z000", 3'b010, 32'h000, 32'h0, 1);
    st("z004", 3'b010, 32'h004, 32'h0, 1);
    st("z008", 3'b010, 32'h008, 32'h0, 1);
    st("zlast", 3'b010, 32'(4*DEPTH-4), 32'h0, 1);
    st("sh007", 3'b001, 32'h007, 32'h1234ABCD, 2);
    ld("lw004", 3'b010, 32'h004, 32'hCD000000, 1);
    ld("lw008", 3'b010, 32'h008, 32'h000000AB, 1);
    ld("lw000a", 3'b010, 32'h000, 32'h00000000, 1);
    st("shwrap", 3'b001, 32'(4*DEPTH-1), 32'h0000ABCD, 2);
    ld("lwlast", 3'b010, 32'(4*DEPTH-4), 32'hCD000000, 1);
    ld("lw000b", 3'b010, 32'h000, 32'h000000AB, 1);
    ld("lwalias", 3'b010, 32'(4*DEPTH), 32'h000000AB, 1);
    ld("lw004b", 3'b010, 32'h004, 32'hCD000000, 1);

    // Illegal funct3.
    bad("lw011", 1'b0, 3'b011, 32'h100, 32'h0);
    bad("sb101", 1'b1, 3'b101, 32'h100, 32'h000000FF);
    bad("lw111", 1'b0, 3'b111, 32'h100, 32'h0);
    ld("lw100b", 3'b010, 32'h100, 32'hDEADBEEF, 1);

    // Reset while the second half of a crossing store is pending.
    st("z400", 3'b010, 32'h400, 32'h0, 1);
    st("z404", 3'b010, 32'h404, 32'h0, 1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h402;
    req_wdata  = 32'hAABBCCDD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("split_busy", 32'(req_ready), 32'd0);
    check("split_novalid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_err", 32'(rsp_err), 32'd0);
    check("abort_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    ld("lw400", 3'b010, 32'h400, 32'hCCDD0000, 1);
    ld("lw404", 3'b010, 32'h404, 32'h00000000, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
